inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction-fetch stage that produces 32-bit instructions for the IF/ID register.
- Fetches over the shared 8-bit byte-serial memory bus through the memory arbiter. Drives a request and address, and receives one byte per granted cycle.
- Contains a direct-mapped instruction cache, so hits skip the bus entirely.
- Handles branch redirects and downstream stalls.

Parameters:
- ICACHE_ENTRIES, 64, number of direct-mapped cache lines (power of two, one 32-bit instruction per line).
- RESET_PC, 32'h0, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready; while low, no state changes.
- stall_i  in  6  arbiter stall vector (bit 5 wb, 4 mem, 3 ex, 2 id, 1 if, 0 if_mem).
- mem_busy_i  in  1  MEM stage owns the bus this cycle; the IF address is not issued.
- mem_din_i  in  8  memory read data, valid one cycle after the address is issued.
- branch_flag_i  in  1  redirect request from EX.
- branch_target_i  in  32  redirect PC.
- if_ctrl_req_o  out  1  IF bus request (Stop = 1).
- if_mem_a_o  out  32  byte address for the current IF request.
- pc_o  out  32  PC of the delivered instruction.
- inst_o  out  32  delivered instruction, little-endian.
- inst_valid_o  out  1  inst_o/pc_o valid; held until accepted.

Behaviour:
- Reset (rst low, asynchronous):
  - pc = RESET_PC; state = IDLE.
  - if_ctrl_req_o = 0; if_mem_a_o = 0; inst_o = 0; pc_o = 0; inst_valid_o = 0.
  - All cache valid bits cleared.
- rdy low: every register holds.
- Grant: an issued byte counts only in cycles where if_ctrl_req_o = 1, mem_busy_i = 0 and rdy = 1. The registered flag issued_q records this, and the byte is captured in the next cycle only if issued_q = 1.
- Cache indexing: index = pc[log2(ICACHE_ENTRIES)+1 : 2]; tag = the remaining upper PC bits.
- Acceptance: an instruction is accepted in a cycle with inst_valid_o = 1 and stall_i[2] = 0. The following edge clears inst_valid_o and sets pc += 4 (32-bit wrap).
- State IDLE (inst_valid_o = 0):
  - Cache lookup on pc.
  - Hit: next edge sets inst_o = line, pc_o = pc, inst_valid_o = 1 (1-cycle hit latency).
  - Miss: go to FETCH with issue_cnt = 0, cap_cnt = 0; no request asserted this cycle.
- State FETCH:
  - if_ctrl_req_o = 1 while issue_cnt < 4, with if_mem_a_o = pc + issue_cnt.
  - issue_cnt increments on each grant.
  - When issued_q = 1, mem_din_i is written to buffer byte cap_cnt and cap_cnt increments.
  - Issue and capture overlap, so an uncontended miss takes 5 cycles from the first request to the 4th byte captured.
  - On the edge the 4th byte is captured:
    - the cache line is written (valid, tag, data);
    - inst_o = assembled word, pc_o = pc, inst_valid_o = 1;
    - go to WAIT.
- State WAIT:
  - Hold all outputs with if_ctrl_req_o = 0.
  - On acceptance, clear inst_valid_o, advance pc and go to IDLE.
  - The cache lookup for the next PC happens in IDLE, so back-to-back hits deliver one instruction every 2 cycles.
- Branch (branch_flag_i = 1, highest priority after reset/rdy):
  - Next edge sets pc = branch_target_i, inst_valid_o = 0, issued_q = 0, issue_cnt = cap_cnt = 0, state = IDLE.
  - if_ctrl_req_o deasserts in the same cycle (combinationally gated).
  - Any in-flight byte is dropped and the partial line is never written to the cache.
- Simultaneous acceptance and branch: the branch wins and the pc += 4 is discarded.
- mem_busy_i for N cycles mid-fetch: the issue pauses for N cycles and captured bytes are retained; the only effect is N extra cycles of latency.
- Misaligned branch_target_i: fetched byte-wise as-is; never cached if pc[1:0] != 0.

Test Plan:
- Reset then release with rdy = 1, memory holding 0x00000013 at address 0:
  - if_mem_a_o sequences 0, 1, 2, 3 on consecutive cycles;
  - inst_o = 0x00000013, pc_o = 0, inst_valid_o = 1 on cycle 5 after the first request.
- Loop refetch of PC 0 after a prior miss fill: no bus request; inst_valid_o one cycle after entering IDLE, with inst_o = 0x00000013.
- mem_busy_i high for 3 cycles after the byte at address 1 is issued:
  - requests for addresses 2 and 3 are delayed 3 cycles;
  - final word is correct and delivery is 3 cycles later than uncontended.
- branch_flag_i with target 0x100 asserted while byte 2 of PC 0x8 is in flight:
  - next request is 0x100;
  - the line for 0x8 stays invalid, and a later fetch of 0x8 misses.
- stall_i[2] held high for 4 cycles with inst_valid_o = 1: inst_o, pc_o and inst_valid_o are stable; pc advances by 4 only after stall_i[2] drops.
- rst pulsed low mid-fetch (cap_cnt = 2):
  - all outputs reach reset values asynchronously;
  - the cache is invalidated;
  - the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------------------------
// inst_fetch: instruction-fetch stage with a direct-mapped instruction cache.
//
// Fetches 32-bit little-endian instructions one byte at a time over the shared byte-serial
// memory bus. Cache hits deliver without touching the bus. Branch redirects from EX abort any
// fetch in progress. Each delivered instruction is held on inst_o/pc_o until ID accepts it.
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous active-low reset
//   rdy              global ready; all state holds while low
//   stall_i[5:0]     arbiter stall vector; only bit 2 (ID stall) gates acceptance
//   mem_busy_i       MEM stage owns the bus this cycle; the IF address is not issued
//   mem_din_i[7:0]   read byte, valid one cycle after its address was issued
//   branch_flag_i    redirect request from EX
//   branch_target_i  redirect PC
//   if_ctrl_req_o    IF bus request
//   if_mem_a_o       byte address of the current IF request
//   pc_o             PC of the delivered instruction
//   inst_o           delivered instruction
//   inst_valid_o     inst_o/pc_o valid, held until accepted
// ---------------------------------------------------------------------------------------------
module inst_fetch #(
   parameter int unsigned ICACHE_ENTRIES = 64,
   parameter logic [31:0] RESET_PC       = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic [5:0]  stall_i,
   input  logic        mem_busy_i,
   input  logic [7:0]  mem_din_i,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_i,
   output logic        if_ctrl_req_o,
   output logic [31:0] if_mem_a_o,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        inst_valid_o
);

   localparam int unsigned IdxW = $clog2(ICACHE_ENTRIES);
   localparam int unsigned TagW = 30 - IdxW;

   typedef enum logic [1:0] {StIdle, StFetch, StWait} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [2:0]  issue_cnt_q, issue_cnt_d;
   logic [1:0]  cap_cnt_q, cap_cnt_d;
   logic        issued_q, issued_d;
   logic [23:0] buf_q, buf_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic        valid_q, valid_d;

   logic [ICACHE_ENTRIES-1:0] cache_valid_q;
   logic [TagW-1:0]           cache_tag_q  [ICACHE_ENTRIES];
   logic [31:0]               cache_data_q [ICACHE_ENTRIES];

   logic [IdxW-1:0] idx;
   logic [TagW-1:0] tag;
   logic            hit;
   logic            req;
   logic            grant;
   logic            accept;
   logic            fill_we;
   logic [31:0]     fill_word;
   logic            unused_stall;

   assign idx       = pc_q[IdxW+1:2];
   assign tag       = pc_q[31:IdxW+2];
   // Misaligned PCs never hit, so they cannot alias an aligned line with the same index/tag.
   assign hit       = cache_valid_q[idx] && (cache_tag_q[idx] == tag) && (pc_q[1:0] == 2'b00);
   // The branch gates the request in the same cycle so no byte of the dead fetch is issued.
   assign req       = (state_q == StFetch) && (issue_cnt_q < 3'd4) && !branch_flag_i;
   assign grant     = req && !mem_busy_i;
   assign accept    = valid_q && !stall_i[2];
   assign fill_word = {mem_din_i, buf_q};

   assign if_ctrl_req_o = req;
   assign if_mem_a_o    = (state_q == StFetch) ? (pc_q + {29'b0, issue_cnt_q}) : 32'h0;
   assign pc_o          = pc_out_q;
   assign inst_o        = inst_q;
   assign inst_valid_o  = valid_q;
   assign unused_stall  = ^{stall_i[5:3], stall_i[1:0]};

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      issue_cnt_d = issue_cnt_q;
      cap_cnt_d   = cap_cnt_q;
      issued_d    = issued_q;
      buf_d       = buf_q;
      inst_d      = inst_q;
      pc_out_d    = pc_out_q;
      valid_d     = valid_q;
      fill_we     = 1'b0;

      if (branch_flag_i) begin
         pc_d        = branch_target_i;
         valid_d     = 1'b0;
         issued_d    = 1'b0;
         issue_cnt_d = '0;
         cap_cnt_d   = '0;
         state_d     = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (hit) begin
                  inst_d   = cache_data_q[idx];
                  pc_out_d = pc_q;
                  valid_d  = 1'b1;
                  state_d  = StWait;
               end else begin
                  issue_cnt_d = '0;
                  cap_cnt_d   = '0;
                  issued_d    = 1'b0;
                  state_d     = StFetch;
               end
            end
            StFetch: begin
               issued_d = grant;
               if (grant) begin
                  issue_cnt_d = issue_cnt_q + 3'd1;
               end
               // mem_din_i carries the byte granted in the previous cycle.
               if (issued_q) begin
                  cap_cnt_d = cap_cnt_q + 2'd1;
                  case (cap_cnt_q)
                     2'd0:    buf_d[7:0]   = mem_din_i;
                     2'd1:    buf_d[15:8]  = mem_din_i;
                     2'd2:    buf_d[23:16] = mem_din_i;
                     default: begin
                        fill_we  = (pc_q[1:0] == 2'b00);
                        inst_d   = fill_word;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        state_d  = StWait;
                     end
                  endcase
               end
            end
            StWait: begin
               if (accept) begin
                  valid_d = 1'b0;
                  pc_d    = pc_q + 32'd4;
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= StIdle;
         pc_q          <= RESET_PC;
         issue_cnt_q   <= '0;
         cap_cnt_q     <= '0;
         issued_q      <= 1'b0;
         buf_q         <= '0;
         inst_q        <= '0;
         pc_out_q      <= '0;
         valid_q       <= 1'b0;
         cache_valid_q <= '0;
      end else if (rdy) begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         issue_cnt_q <= issue_cnt_d;
         cap_cnt_q   <= cap_cnt_d;
         issued_q    <= issued_d;
         buf_q       <= buf_d;
         inst_q      <= inst_d;
         pc_out_q    <= pc_out_d;
         valid_q     <= valid_d;
         if (fill_we) begin
            cache_valid_q[idx] <= 1'b1;
         end
      end
   end

   // Tag/data storage needs no reset; the valid bits alone gate every hit.
   always_ff @(posedge clk) begin
      if (rdy && fill_we) begin
         cache_tag_q[idx]  <= tag;
         cache_data_q[idx] <= fill_word;
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic [5:0]  stall_i;
   logic        mem_busy_i;
   logic [7:0]  mem_din_i;
   logic        branch_flag_i;
   logic [31:0] branch_target_i;
   logic        if_ctrl_req_o;
   logic [31:0] if_mem_a_o;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        inst_valid_o;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0]  mem [4096];
   bit          m_v  [64];
   logic [31:0] m_pc [64];

   logic [31:0] exp_pc;
   int          grants;
   int          deliveries;
   bit          last_v;
   bit          hit;

   inst_fetch #(
      .ICACHE_ENTRIES(64),
      .RESET_PC      (32'h0)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .stall_i        (stall_i),
      .mem_busy_i     (mem_busy_i),
      .mem_din_i      (mem_din_i),
      .branch_flag_i  (branch_flag_i),
      .branch_target_i(branch_target_i),
      .if_ctrl_req_o  (if_ctrl_req_o),
      .if_mem_a_o     (if_mem_a_o),
      .pc_o           (pc_o),
      .inst_o         (inst_o),
      .inst_valid_o   (inst_valid_o)
   );

   always #5 clk = ~clk;

   // Byte-serial memory: returns the byte at the address presented in the previous cycle.
   always @(posedge clk) mem_din_i <= mem[if_mem_a_o[11:0]];

   function automatic logic [31:0] word_at(input logic [31:0] a);
      logic [11:0] b;
      b = a[11:0];
      return {mem[b + 12'd3], mem[b + 12'd2], mem[b + 12'd1], mem[b]};
   endfunction

   function automatic bit model_hit(input logic [31:0] a);
      return (a[1:0] == 2'b00) && m_v[a[7:2]] && (m_pc[a[7:2]] == a);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (inst_valid_o !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check(tag, {31'b0, inst_valid_o}, 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"},   {31'b0, if_ctrl_req_o}, 32'd0);
      check({tag, "_addr"},  if_mem_a_o, 32'd0);
      check({tag, "_inst"},  inst_o, 32'd0);
      check({tag, "_pc"},    pc_o, 32'd0);
      check({tag, "_valid"}, {31'b0, inst_valid_o}, 32'd0);
   endtask

   initial begin
      rst             = 1'b0;
      rdy             = 1'b1;
      stall_i         = '0;
      mem_busy_i      = 1'b0;
      branch_flag_i   = 1'b0;
      branch_target_i = '0;
      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
      mem[0] = 8'h13;
      mem[1] = 8'h00;
      mem[2] = 8'h00;
      mem[3] = 8'h00;

      // Reset values while held in reset.
      #12;
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Cold miss at PC 0: four consecutive byte requests, word on cycle 5.
      tick();
      check("miss0_req", {31'b0, if_ctrl_req_o}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         check("miss0_addr", if_mem_a_o, i);
      end
      tick();
      check("miss0_req_done", {31'b0, if_ctrl_req_o}, 32'd0);
      check("miss0_not_yet", {31'b0, inst_valid_o}, 32'd0);
      tick();
      check("miss0_valid", {31'b0, inst_valid_o}, 32'd1);
      check("miss0_inst", inst_o, 32'h0000_0013);
      check("miss0_pc", pc_o, 32'h0);

      // ID stall holds the delivered instruction.
      stall_i = 6'b000100;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("stall_valid", {31'b0, inst_valid_o}, 32'd1);
         check("stall_inst", inst_o, 32'h0000_0013);
         check("stall_pc", pc_o, 32'h0);
      end
      // rdy low freezes everything even with the stall released.
      stall_i = '0;
      rdy     = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rdy_hold_valid", {31'b0, inst_valid_o}, 32'd1);
      end
      rdy = 1'b1;
      tick();
      check("accept_clears", {31'b0, inst_valid_o}, 32'd0);
      tick();
      check("pc4_req", {31'b0, if_ctrl_req_o}, 32'd1);
      check("pc4_addr", if_mem_a_o, 32'h4);
      wait_valid("pc4_wait");
      check("pc4_inst", inst_o, word_at(32'h4));
      check("pc4_pc", pc_o, 32'h4);

      // Branch back to 0 while accepting: branch wins, line 0 hits with no bus request.
      branch_flag_i   = 1'b1;
      branch_target_i = 32'h0;
      tick();
      branch_flag_i = 1'b0;
      check("br0_valid", {31'b0, inst_valid_o}, 32'd0);
      check("br0_req", {31'b0, if_ctrl_req_o}, 32'd0);
      tick();
      check("hit0_valid", {31'b0, inst_valid_o}, 32'd1);
      check("hit0_inst", inst_o, 32'h0000_0013);
      check("hit0_pc", pc_o, 32'h0);
      check("hit0_req", {31'b0, if_ctrl_req_o}, 32'd0);
      tick();
      check("hit4_gap", {31'b0, inst_valid_o}, 32'd0);
      tick();
      check("hit4_valid", {31'b0, inst_valid_o}, 32'd1);
      check("hit4_pc", pc_o, 32'h4);
      check("hit4_inst", inst_o, word_at(32'h4));

      // Miss at 0x8, branch to 0x100 while byte 2 is in flight.
      tick();
      tick();
      check("pc8_addr0", if_mem_a_o, 32'h8);
      tick();
      tick();
      tick();
      check("pc8_addr3", if_mem_a_o, 32'hb);
      branch_flag_i   = 1'b1;
      branch_target_i = 32'h100;
      #1;
      check("br100_gate", {31'b0, if_ctrl_req_o}, 32'd0);
      tick();
      branch_flag_i = 1'b0;
      check("br100_valid", {31'b0, inst_valid_o}, 32'd0);
      tick();
      check("br100_req", {31'b0, if_ctrl_req_o}, 32'd1);
      check("br100_addr", if_mem_a_o, 32'h100);
      wait_valid("pc100_wait");
      check("pc100_inst", inst_o, word_at(32'h100));
      check("pc100_pc", pc_o, 32'h100);

      // Refetch 0x8 must miss; busy for 3 cycles once byte 1 is issued.
      branch_flag_i   = 1'b1;
      branch_target_i = 32'h8;
      tick();
      branch_flag_i = 1'b0;
      tick();
      check("re8_req", {31'b0, if_ctrl_req_o}, 32'd1);
      check("re8_addr", if_mem_a_o, 32'h8);
      tick();
      tick();
      mem_busy_i = 1'b1;
      check("busy_addr", if_mem_a_o, 32'ha);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("busy_addr", if_mem_a_o, 32'ha);
      end
      tick();
      mem_busy_i = 1'b0;
      check("busy_resume", if_mem_a_o, 32'ha);
      tick();
      check("busy_addr3", if_mem_a_o, 32'hb);
      tick();
      check("busy_not_yet", {31'b0, inst_valid_o}, 32'd0);
      tick();
      check("busy_valid", {31'b0, inst_valid_o}, 32'd1);
      check("busy_inst", inst_o, word_at(32'h8));
      check("busy_pc", pc_o, 32'h8);

      // Asynchronous reset mid-fetch of 0xC after two bytes are captured.
      tick();
      tick();
      check("pc12_addr", if_mem_a_o, 32'hc);
      tick();
      tick();
      tick();
      #2;
      rst = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      @(posedge clk);
      #1;
      rst = 1'b1;
      tick();
      check("rst_refetch_req", {31'b0, if_ctrl_req_o}, 32'd1);
      check("rst_refetch_addr", if_mem_a_o, 32'h0);
      wait_valid("rst_refetch_wait");
      check("rst_refetch_inst", inst_o, 32'h0000_0013);

      // Randomized phase against a transaction-level model.
      rst = 1'b0;
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 64; i++) m_v[i] = 1'b0;
      exp_pc     = 32'h0;
      grants     = 0;
      deliveries = 0;
      last_v     = 1'b0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         if (inst_valid_o && !last_v) begin
            hit = model_hit(exp_pc);
            check("rnd_pc", pc_o, exp_pc);
            check("rnd_inst", inst_o, word_at(exp_pc));
            check("rnd_bus_bytes", 32'(grants), hit ? 32'd0 : 32'd4);
            if (!hit && exp_pc[1:0] == 2'b00) begin
               m_v[exp_pc[7:2]]  = 1'b1;
               m_pc[exp_pc[7:2]] = exp_pc;
            end
            grants = 0;
            deliveries++;
         end
         last_v          = inst_valid_o;
         stall_i         = 6'($urandom);
         stall_i[2]      = ($urandom_range(0, 2) == 0);
         mem_busy_i      = ($urandom_range(0, 3) == 0);
         branch_flag_i   = ($urandom_range(0, 11) == 0);
         branch_target_i = 32'($urandom_range(0, 63)) * 32'd4;
         if ($urandom_range(0, 7) == 0) branch_target_i = branch_target_i + 32'($urandom_range(1, 3));
         #1;
         if (if_ctrl_req_o && !mem_busy_i) grants++;
         if (branch_flag_i) begin
            exp_pc = branch_target_i;
            grants = 0;
         end else if (inst_valid_o && !stall_i[2]) begin
            exp_pc = exp_pc + 32'd4;
         end
         tick();
      end
      branch_flag_i = 1'b0;
      check("rnd_enough_deliveries", 32'(deliveries >= 20), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
